// File: rtl/decode_exec_core_if.sv
// decode_exec_core_if: bundles the decode/execute core's pipeline-facing
// signals. The master side drives the instruction/EX/writeback inputs
// (fetch register and writeback stage); the slave side is the core itself.
interface decode_exec_core_if;
  logic [31:0] instr;
  logic [31:0] ex_instr;
  logic [31:0] R_EX;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;

  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [11:0] imm_i;
  logic [19:0] imm_u;
  logic [6:0]  opcode;
  logic [3:0]  aluop;
  logic        alusrc;
  logic [1:0]  regsel;
  logic        regwrite;
  logic        gpio_we;
  logic [31:0] readdata1;
  logic [31:0] readdata2;
  logic [31:0] alu_R;
  logic        alu_zero;
  logic [1:0]  pcsrc_EX;
  logic        stall_FETCH;

  modport master (
    output instr, ex_instr, R_EX, wb_we, wb_addr, wb_data,
    input  rd, rs1, rs2, imm_i, imm_u, opcode, aluop, alusrc, regsel,
           regwrite, gpio_we, readdata1, readdata2, alu_R, alu_zero,
           pcsrc_EX, stall_FETCH
  );

  modport slave (
    input  instr, ex_instr, R_EX, wb_we, wb_addr, wb_data,
    output rd, rs1, rs2, imm_i, imm_u, opcode, aluop, alusrc, regsel,
           regwrite, gpio_we, readdata1, readdata2, alu_R, alu_zero,
           pcsrc_EX, stall_FETCH
  );
endinterface

// File: rtl/decode_exec_core.sv
// decode_exec_core: instruction decode, 32x32 register file, ALU,
// EX-stage control-transfer resolution and fetch stall for the RV32 pipeline.
// Optional feature macro: MUL_EN (enables MUL/MULH/MULHU; without it those
// aluop codes return 0 and funct7=0x01 R-type instructions decode as NOP).
//
// Stall FSM
//   state   | meaning
//   ST_RUN  | no stall issued last cycle; a control transfer in decode stalls fetch
//   ST_HELD | fetch stalled last cycle; the held instruction proceeds unstalled
module decode_exec_core (
  input  logic clk,
  input  logic rst,
  decode_exec_core_if.slave bus
);
  localparam logic [6:0] OP_R    = 7'h33;
  localparam logic [6:0] OP_I    = 7'h13;
  localparam logic [6:0] OP_LUI  = 7'h37;
  localparam logic [6:0] OP_CSR  = 7'h73;
  localparam logic [6:0] OP_BR   = 7'h63;
  localparam logic [6:0] OP_JAL  = 7'h6F;
  localparam logic [6:0] OP_JALR = 7'h67;

  localparam logic [3:0] ALU_AND   = 4'b0000;
  localparam logic [3:0] ALU_OR    = 4'b0001;
  localparam logic [3:0] ALU_XOR   = 4'b0010;
  localparam logic [3:0] ALU_ADD   = 4'b0011;
  localparam logic [3:0] ALU_SUB   = 4'b0100;
  localparam logic [3:0] ALU_MUL   = 4'b0101;
  localparam logic [3:0] ALU_MULH  = 4'b0110;
  localparam logic [3:0] ALU_MULHU = 4'b0111;
  localparam logic [3:0] ALU_SLL   = 4'b1000;
  localparam logic [3:0] ALU_SRL   = 4'b1001;
  localparam logic [3:0] ALU_SRA   = 4'b1010;
  localparam logic [3:0] ALU_SLT   = 4'b1011;
  localparam logic [3:0] ALU_SLTU  = 4'b1100;

  typedef enum logic {ST_RUN, ST_HELD} stall_state_t;

  stall_state_t state_q, state_d;

  logic [6:0]  op;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [4:0]  rd_a, rs1_a, rs2_a;
  logic [11:0] imm_i;
  logic [6:0]  ex_op;
  logic [2:0]  ex_f3;
  logic        unused_ex;

  logic [3:0]  aluop;
  logic        alusrc;
  logic [1:0]  regsel;
  logic        regwrite;
  logic        gpio_we;

  logic [31:0] regs [32];
  logic [31:0] rdata1, rdata2;
  logic [31:0] a_op, b_op, alu_res;
  logic [1:0]  pcsrc;
  logic        is_xfer, stall;

  assign op    = bus.instr[6:0];
  assign rd_a  = bus.instr[11:7];
  assign f3    = bus.instr[14:12];
  assign rs1_a = bus.instr[19:15];
  assign rs2_a = bus.instr[24:20];
  assign f7    = bus.instr[31:25];
  assign imm_i = bus.instr[31:20];

  assign ex_op     = bus.ex_instr[6:0];
  assign ex_f3     = bus.ex_instr[14:12];
  assign unused_ex = ^{bus.ex_instr[31:15], bus.ex_instr[11:7]};

  // Control decode; all-zero defaults make unknown encodings a NOP
  always_comb begin
    aluop    = ALU_AND;
    alusrc   = 1'b0;
    regsel   = 2'b00;
    regwrite = 1'b0;
    gpio_we  = 1'b0;
    case (op)
      OP_R: begin
        regsel   = 2'b10;
        regwrite = 1'b1;
        case (f7)
          7'h00: begin
            case (f3)
              3'd0:    aluop = ALU_ADD;
              3'd1:    aluop = ALU_SLL;
              3'd2:    aluop = ALU_SLT;
              3'd3:    aluop = ALU_SLTU;
              3'd4:    aluop = ALU_XOR;
              3'd5:    aluop = ALU_SRL;
              3'd6:    aluop = ALU_OR;
              default: aluop = ALU_AND;
            endcase
          end
          7'h20: begin
            if (f3 == 3'd0)      aluop = ALU_SUB;
            else if (f3 == 3'd5) aluop = ALU_SRA;
          end
          7'h01: begin
`ifdef MUL_EN
            case (f3)
              3'd0:    aluop = ALU_MUL;
              3'd1:    aluop = ALU_MULH;
              3'd3:    aluop = ALU_MULHU;
              default: aluop = ALU_AND;
            endcase
`else
            regsel   = 2'b00;
            regwrite = 1'b0;
`endif
          end
          default: ;
        endcase
      end
      OP_I: begin
        alusrc   = 1'b1;
        regsel   = 2'b10;
        regwrite = 1'b1;
        case (f3)
          3'd0:    aluop = ALU_ADD;
          3'd1:    aluop = ALU_SLL;
          3'd2:    aluop = ALU_SLT;
          3'd3:    aluop = ALU_SLTU;
          3'd4:    aluop = ALU_XOR;
          3'd5:    aluop = bus.instr[30] ? ALU_SRA : ALU_SRL;
          3'd6:    aluop = ALU_OR;
          default: aluop = ALU_AND;
        endcase
      end
      OP_LUI: begin
        regsel   = 2'b01;
        regwrite = 1'b1;
        aluop    = ALU_ADD;
        alusrc   = 1'b1;
      end
      OP_CSR: begin
        if (imm_i == 12'hF00) begin
          regsel   = 2'b00;
          regwrite = (rd_a != 5'd0);
        end else if (imm_i == 12'hF02) begin
          gpio_we  = 1'b1;
        end
      end
      OP_BR: begin
        case (f3)
          3'd0, 3'd1: aluop = ALU_SUB;
          3'd4, 3'd5: aluop = ALU_SLT;
          3'd6, 3'd7: aluop = ALU_SLTU;
          default:    aluop = ALU_AND;
        endcase
      end
      OP_JAL: begin
        regsel   = 2'b11;
        regwrite = 1'b1;
      end
      OP_JALR: begin
        regsel   = 2'b11;
        regwrite = 1'b1;
        alusrc   = 1'b1;
        aluop    = ALU_ADD;
      end
      default: ;
    endcase
  end

  // Register array: synchronous clear has priority over writeback; x0 never written
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (bus.wb_we && (bus.wb_addr != 5'd0)) begin
      regs[bus.wb_addr] <= bus.wb_data;
    end
  end

  // Read port 1 with x0 forced to zero and same-cycle writeback bypass
  always_comb begin
    rdata1 = regs[rs1_a];
    if (rs1_a == 5'd0)                              rdata1 = '0;
    else if (bus.wb_we && (bus.wb_addr == rs1_a))   rdata1 = bus.wb_data;
  end

  // Read port 2 with x0 forced to zero and same-cycle writeback bypass
  always_comb begin
    rdata2 = regs[rs2_a];
    if (rs2_a == 5'd0)                              rdata2 = '0;
    else if (bus.wb_we && (bus.wb_addr == rs2_a))   rdata2 = bus.wb_data;
  end

  assign a_op = (op == OP_LUI) ? 32'd0 : rdata1;
  assign b_op = alusrc ? {{20{imm_i[11]}}, imm_i} : rdata2;

`ifdef MUL_EN
  // One signed 64-bit product; the unsigned high word is recovered by adding
  // back b when a is negative and a when b is negative (mod 2^32).
  logic signed [63:0] prod_ss;
  logic [31:0]        mulhu_hi;
  assign prod_ss  = $signed({{32{a_op[31]}}, a_op}) * $signed({{32{b_op[31]}}, b_op});
  assign mulhu_hi = prod_ss[63:32] + (a_op[31] ? b_op : 32'd0) + (b_op[31] ? a_op : 32'd0);
`endif

  // ALU datapath
  always_comb begin
    alu_res = '0;
    case (aluop)
      ALU_AND:   alu_res = a_op & b_op;
      ALU_OR:    alu_res = a_op | b_op;
      ALU_XOR:   alu_res = a_op ^ b_op;
      ALU_ADD:   alu_res = a_op + b_op;
      ALU_SUB:   alu_res = a_op - b_op;
`ifdef MUL_EN
      ALU_MUL:   alu_res = prod_ss[31:0];
      ALU_MULH:  alu_res = prod_ss[63:32];
      ALU_MULHU: alu_res = mulhu_hi;
`endif
      ALU_SLL:   alu_res = a_op << b_op[4:0];
      ALU_SRL:   alu_res = a_op >> b_op[4:0];
      ALU_SRA:   alu_res = $unsigned($signed(a_op) >>> b_op[4:0]);
      ALU_SLT:   alu_res = {31'd0, $signed(a_op) < $signed(b_op)};
      ALU_SLTU:  alu_res = {31'd0, a_op < b_op};
      default:   alu_res = '0;
    endcase
  end

  // Next-PC source for the instruction in EX
  always_comb begin
    pcsrc = 2'b00;
    case (ex_op)
      OP_JAL:  pcsrc = 2'b10;
      OP_JALR: pcsrc = 2'b01;
      OP_BR: begin
        case (ex_f3)
          3'd0:       if (bus.R_EX == 32'd0) pcsrc = 2'b11;
          3'd1:       if (bus.R_EX != 32'd0) pcsrc = 2'b11;
          3'd4, 3'd6: if (bus.R_EX[0])       pcsrc = 2'b11;
          3'd5, 3'd7: if (!bus.R_EX[0])      pcsrc = 2'b11;
          default:    pcsrc = 2'b00;
        endcase
      end
      default: ;
    endcase
  end

  assign is_xfer = (op == OP_BR) || (op == OP_JAL) || (op == OP_JALR);

  // Stall state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_RUN;
    else     state_q <= state_d;
  end

  // Stall decision: only the first decode cycle of a control transfer holds fetch
  always_comb begin
    stall   = 1'b0;
    state_d = ST_RUN;
    if (is_xfer && (state_q == ST_RUN)) begin
      stall   = 1'b1;
      state_d = ST_HELD;
    end
  end

  assign bus.rd          = rd_a;
  assign bus.rs1         = rs1_a;
  assign bus.rs2         = rs2_a;
  assign bus.imm_i       = imm_i;
  assign bus.imm_u       = bus.instr[31:12];
  assign bus.opcode      = op;
  assign bus.aluop       = aluop;
  assign bus.alusrc      = alusrc;
  assign bus.regsel      = regsel;
  assign bus.regwrite    = regwrite;
  assign bus.gpio_we     = gpio_we;
  assign bus.readdata1   = rdata1;
  assign bus.readdata2   = rdata2;
  assign bus.alu_R       = alu_res;
  assign bus.alu_zero    = (alu_res == 32'd0);
  assign bus.pcsrc_EX    = pcsrc;
  assign bus.stall_FETCH = stall;
endmodule

// File: tb/tb_decode_exec_core.sv
// tb_decode_exec_core: directed literal checks followed by randomized
// instruction/writeback traffic compared every cycle against an
// instruction-semantics model of the decode/execute core.
module tb_decode_exec_core;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  decode_exec_core_if bus ();
  decode_exec_core dut (.clk(clk), .rst(rst), .bus(bus));

  int total = 0;
  int bad   = 0;
  logic check_en = 1'b0;

  logic [31:0] mregs [32];
  logic        prev_stall;

  typedef struct packed {
    logic [3:0]  aluop;
    logic        alusrc;
    logic [1:0]  regsel;
    logic        regwrite;
    logic        gpio_we;
    logic [31:0] res;
  } exp_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (bus.wb_we && bus.wb_addr == a) return bus.wb_data;
    return mregs[a];
  endfunction

  function automatic logic is_xfer(input logic [31:0] ins);
    return ins[6:0] == 7'h63 || ins[6:0] == 7'h6F || ins[6:0] == 7'h67;
  endfunction

  function automatic logic [1:0] m_pcsrc(input logic [31:0] ins, input logic [31:0] r);
    logic taken;
    case (ins[6:0])
      7'h6F: return 2'b10;
      7'h67: return 2'b01;
      7'h63: begin
        case (ins[14:12])
          3'd0:       taken = (r == 32'd0);
          3'd1:       taken = (r != 32'd0);
          3'd4, 3'd6: taken = r[0];
          3'd5, 3'd7: taken = !r[0];
          default:    taken = 1'b0;
        endcase
        return taken ? 2'b11 : 2'b00;
      end
      default: return 2'b00;
    endcase
  endfunction

  // Expected control and ALU result from instruction semantics; x1v/x2v are
  // the register values named by rs1/rs2.
  function automatic exp_t m_decode(input logic [31:0] ins, input logic [31:0] x1v,
                                    input logic [31:0] x2v);
    exp_t        e;
    logic [31:0] imm;
    logic [2:0]  f3;
    logic [6:0]  f7;
`ifdef MUL_EN
    longint      ps;
    logic [63:0] pu;
`endif
    f3  = ins[14:12];
    f7  = ins[31:25];
    imm = {{20{ins[31]}}, ins[31:20]};
    e = '0;
    e.res = x1v & x2v;
    case (ins[6:0])
      7'h33: begin
        e.regsel = 2'b10; e.regwrite = 1'b1;
        case ({f7, f3})
          {7'h00, 3'd0}: begin e.aluop = 4'd3;  e.res = x1v + x2v; end
          {7'h00, 3'd1}: begin e.aluop = 4'd8;  e.res = x1v << x2v[4:0]; end
          {7'h00, 3'd2}: begin e.aluop = 4'd11; e.res = {31'd0, $signed(x1v) < $signed(x2v)}; end
          {7'h00, 3'd3}: begin e.aluop = 4'd12; e.res = {31'd0, x1v < x2v}; end
          {7'h00, 3'd4}: begin e.aluop = 4'd2;  e.res = x1v ^ x2v; end
          {7'h00, 3'd5}: begin e.aluop = 4'd9;  e.res = x1v >> x2v[4:0]; end
          {7'h00, 3'd6}: begin e.aluop = 4'd1;  e.res = x1v | x2v; end
          {7'h00, 3'd7}: begin e.aluop = 4'd0;  e.res = x1v & x2v; end
          {7'h20, 3'd0}: begin e.aluop = 4'd4;  e.res = x1v - x2v; end
          {7'h20, 3'd5}: begin e.aluop = 4'd10; e.res = $unsigned($signed(x1v) >>> x2v[4:0]); end
`ifdef MUL_EN
          {7'h01, 3'd0}: begin e.aluop = 4'd5; e.res = x1v * x2v; end
          {7'h01, 3'd1}: begin
            e.aluop = 4'd6;
            ps = longint'($signed(x1v)) * longint'($signed(x2v));
            e.res = ps[63:32];
          end
          {7'h01, 3'd3}: begin
            e.aluop = 4'd7;
            pu = {32'd0, x1v} * {32'd0, x2v};
            e.res = pu[63:32];
          end
`else
          {7'h01, 3'd0}, {7'h01, 3'd1}, {7'h01, 3'd3}: begin
            e.regsel = 2'b00; e.regwrite = 1'b0;
          end
`endif
          default: ;
        endcase
      end
      7'h13: begin
        e.alusrc = 1'b1; e.regsel = 2'b10; e.regwrite = 1'b1;
        e.res = x1v & imm;
        case (f3)
          3'd0: begin e.aluop = 4'd3;  e.res = x1v + imm; end
          3'd1: begin e.aluop = 4'd8;  e.res = x1v << imm[4:0]; end
          3'd2: begin e.aluop = 4'd11; e.res = {31'd0, $signed(x1v) < $signed(imm)}; end
          3'd3: begin e.aluop = 4'd12; e.res = {31'd0, x1v < imm}; end
          3'd4: begin e.aluop = 4'd2;  e.res = x1v ^ imm; end
          3'd5: begin
            if (ins[30]) begin e.aluop = 4'd10; e.res = $unsigned($signed(x1v) >>> imm[4:0]); end
            else         begin e.aluop = 4'd9;  e.res = x1v >> imm[4:0]; end
          end
          3'd6: begin e.aluop = 4'd1;  e.res = x1v | imm; end
          default: ;
        endcase
      end
      7'h37: begin
        e.regsel = 2'b01; e.regwrite = 1'b1; e.aluop = 4'd3; e.alusrc = 1'b1;
        e.res = imm;
      end
      7'h73: begin
        if (ins[31:20] == 12'hF00) begin
          e.regwrite = (ins[11:7] != 5'd0);
        end else if (ins[31:20] == 12'hF02) begin
          e.gpio_we = 1'b1;
        end
      end
      7'h63: begin
        case (f3)
          3'd0, 3'd1: begin e.aluop = 4'd4;  e.res = x1v - x2v; end
          3'd4, 3'd5: begin e.aluop = 4'd11; e.res = {31'd0, $signed(x1v) < $signed(x2v)}; end
          3'd6, 3'd7: begin e.aluop = 4'd12; e.res = {31'd0, x1v < x2v}; end
          default: ;
        endcase
      end
      7'h6F: begin e.regsel = 2'b11; e.regwrite = 1'b1; end
      7'h67: begin
        e.regsel = 2'b11; e.regwrite = 1'b1; e.alusrc = 1'b1; e.aluop = 4'd3;
        e.res = x1v + imm;
      end
      default: ;
    endcase
    return e;
  endfunction

  function automatic logic [31:0] mk_r(input logic [6:0] f7, input logic [4:0] r2,
                                       input logic [4:0] r1, input logic [2:0] f3,
                                       input logic [4:0] rdn);
    return {f7, r2, r1, f3, rdn, 7'h33};
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [4:0]  rdn, r1, r2;
    logic [2:0]  f3;
    logic [11:0] imm;
    logic [6:0]  op;
    int          k;
    rdn = 5'($urandom); r1 = 5'($urandom); r2 = 5'($urandom);
    f3  = 3'($urandom); imm = 12'($urandom);
    case ($urandom_range(0, 11))
      0, 1, 2: begin
        k = $urandom_range(0, 12);
        if (k < 8)       return mk_r(7'h00, r2, r1, f3, rdn);
        else if (k == 8) return mk_r(7'h20, r2, r1, 3'd0, rdn);
        else if (k == 9) return mk_r(7'h20, r2, r1, 3'd5, rdn);
        else if (k == 10) return mk_r(7'h01, r2, r1, 3'd0, rdn);
        else if (k == 11) return mk_r(7'h01, r2, r1, 3'd1, rdn);
        else             return mk_r(7'h01, r2, r1, 3'd3, rdn);
      end
      3, 4: begin
        if (f3 == 3'd1) imm[11:5] = 7'h00;
        if (f3 == 3'd5) imm[11:5] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
        return {imm, r1, f3, rdn, 7'h13};
      end
      5: return {20'($urandom), rdn, 7'h37};
      6: begin
        k = $urandom_range(0, 2);
        if (k == 0)      imm = 12'hF00;
        else if (k == 1) imm = 12'hF02;
        return {imm, r1, 3'd1, rdn, 7'h73};
      end
      7, 8: begin
        k  = $urandom_range(0, 5);
        f3 = (k < 2) ? 3'(k) : 3'(k + 2);
        return {imm[11:5], r2, r1, f3, imm[4:0], 7'h63};
      end
      9:  return {20'($urandom), rdn, 7'h6F};
      10: return {imm, r1, 3'd0, rdn, 7'h67};
      default: begin
        op = 7'($urandom);
        if (op == 7'h33 || op == 7'h13 || op == 7'h37 || op == 7'h73 ||
            op == 7'h63 || op == 7'h6F || op == 7'h67) op = 7'h00;
        return {25'($urandom), op};
      end
    endcase
  endfunction

  // Model state: register contents and whether fetch was stalled last cycle
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) mregs[i] <= 32'd0;
      prev_stall <= 1'b0;
    end else begin
      prev_stall <= is_xfer(bus.instr) && !prev_stall;
      if (bus.wb_we && bus.wb_addr != 5'd0) mregs[bus.wb_addr] <= bus.wb_data;
    end
  end

  // Every-cycle comparison of all outputs against the model
  always @(negedge clk) begin
    logic [31:0] r1, r2;
    exp_t        e;
    if (check_en) begin
      r1 = m_read(bus.instr[19:15]);
      r2 = m_read(bus.instr[24:20]);
      e  = m_decode(bus.instr, r1, r2);
      chk("rd",        32'(bus.rd),       32'(bus.instr[11:7]));
      chk("rs1",       32'(bus.rs1),      32'(bus.instr[19:15]));
      chk("rs2",       32'(bus.rs2),      32'(bus.instr[24:20]));
      chk("imm_i",     32'(bus.imm_i),    32'(bus.instr[31:20]));
      chk("imm_u",     32'(bus.imm_u),    32'(bus.instr[31:12]));
      chk("opcode",    32'(bus.opcode),   32'(bus.instr[6:0]));
      chk("aluop",     32'(bus.aluop),    32'(e.aluop));
      chk("alusrc",    32'(bus.alusrc),   32'(e.alusrc));
      chk("regsel",    32'(bus.regsel),   32'(e.regsel));
      chk("regwrite",  32'(bus.regwrite), 32'(e.regwrite));
      chk("gpio_we",   32'(bus.gpio_we),  32'(e.gpio_we));
      chk("readdata1", bus.readdata1, r1);
      chk("readdata2", bus.readdata2, r2);
      chk("alu_R",     bus.alu_R, e.res);
      chk("alu_zero",  32'(bus.alu_zero), 32'(e.res == 32'd0));
      chk("pcsrc_EX",  32'(bus.pcsrc_EX), 32'(m_pcsrc(bus.ex_instr, bus.R_EX)));
      chk("stall_FETCH", 32'(bus.stall_FETCH), 32'(is_xfer(bus.instr) && !prev_stall));
    end
  end

  task automatic settle;
    @(negedge clk);
  endtask

  task automatic adv;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    bus.wb_we = 1'b1; bus.wb_addr = a; bus.wb_data = d;
    adv();
    bus.wb_we = 1'b0;
  endtask

  localparam logic [31:0] BEQ  = 32'h00208063;
  localparam logic [31:0] NOP  = 32'h00000013;

  initial begin
    rst = 1'b1;
    bus.instr = NOP; bus.ex_instr = 32'd0; bus.R_EX = 32'd0;
    bus.wb_we = 1'b0; bus.wb_addr = 5'd0; bus.wb_data = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_en = 1'b1;

    for (int i = 0; i < 32; i++) begin
      bus.instr = mk_r(7'h00, 5'd0, 5'(i), 3'd0, 5'd0);
      settle();
      chk("reset_reg", bus.readdata1, 32'd0);
      adv();
    end

    bus.instr = mk_r(7'h00, 5'd0, 5'd5, 3'd0, 5'd0);
    bus.wb_we = 1'b1; bus.wb_addr = 5'd5; bus.wb_data = 32'h12345678;
    settle();
    chk("bypass_x5", bus.readdata1, 32'h12345678);
    adv();
    bus.wb_we = 1'b0;
    settle();
    chk("stored_x5", bus.readdata1, 32'h12345678);
    adv();

    bus.instr = mk_r(7'h00, 5'd0, 5'd0, 3'd0, 5'd0);
    bus.wb_we = 1'b1; bus.wb_addr = 5'd0; bus.wb_data = 32'hDEADBEEF;
    settle();
    chk("x0_bypass", bus.readdata1, 32'd0);
    adv();
    bus.wb_we = 1'b0;
    settle();
    chk("x0_stored", bus.readdata1, 32'd0);
    adv();

    wr(5'd1, 32'hFFFFFFF0);
    wr(5'd2, 32'd4);

    bus.instr = 32'h00A00093;
    settle();
    chk("addi_regwrite", 32'(bus.regwrite), 32'd1);
    chk("addi_regsel",   32'(bus.regsel),   32'd2);
    chk("addi_alusrc",   32'(bus.alusrc),   32'd1);
    chk("addi_alu_R",    bus.alu_R,         32'd10);
    adv();

    bus.instr = mk_r(7'h20, 5'd2, 5'd1, 3'd5, 5'd3);
    settle(); chk("sra", bus.alu_R, 32'hFFFFFFFF); adv();
    bus.instr = mk_r(7'h00, 5'd2, 5'd1, 3'd5, 5'd3);
    settle(); chk("srl", bus.alu_R, 32'h0FFFFFFF); adv();
    bus.instr = mk_r(7'h00, 5'd2, 5'd1, 3'd2, 5'd3);
    settle(); chk("slt", bus.alu_R, 32'd1); adv();
    bus.instr = mk_r(7'h00, 5'd2, 5'd1, 3'd3, 5'd3);
    settle(); chk("sltu", bus.alu_R, 32'd0); adv();

    wr(5'd2, 32'hFFFFFFFF);
    bus.instr = mk_r(7'h01, 5'd2, 5'd1, 3'd1, 5'd3);
    settle();
`ifdef MUL_EN
    chk("mulh", bus.alu_R, 32'h00000000);
    chk("mulh_regwrite", 32'(bus.regwrite), 32'd1);
    adv();
    bus.instr = mk_r(7'h01, 5'd2, 5'd1, 3'd3, 5'd3);
    settle();
    chk("mulhu", bus.alu_R, 32'hFFFFFFEF);
`else
    chk("mulh_nop_regwrite", 32'(bus.regwrite), 32'd0);
    chk("mulh_nop_alu_R", bus.alu_R, 32'hFFFFFFF0);
`endif
    adv();

    bus.instr = 32'h123450B7;
    settle();
    chk("lui_regsel", 32'(bus.regsel), 32'd1);
    chk("lui_imm_u",  32'(bus.imm_u),  32'h12345);
    adv();

    bus.instr = {12'hF02, 5'd1, 3'd1, 5'd0, 7'h73};
    settle();
    chk("csr_gpio_we",  32'(bus.gpio_we),  32'd1);
    chk("csr_regwrite", 32'(bus.regwrite), 32'd0);
    adv();

    bus.instr = NOP;
    bus.ex_instr = BEQ; bus.R_EX = 32'd0;
    settle(); chk("beq_taken", 32'(bus.pcsrc_EX), 32'd3); adv();
    bus.R_EX = 32'd1;
    settle(); chk("beq_not_taken", 32'(bus.pcsrc_EX), 32'd0); adv();
    bus.ex_instr = 32'h0020D063; bus.R_EX = 32'd0;
    settle(); chk("bge_taken", 32'(bus.pcsrc_EX), 32'd3); adv();
    bus.ex_instr = 32'h0000006F;
    settle(); chk("jal", 32'(bus.pcsrc_EX), 32'd2); adv();
    bus.ex_instr = 32'h00000067;
    settle(); chk("jalr", 32'(bus.pcsrc_EX), 32'd1); adv();
    bus.ex_instr = 32'd0;

    bus.instr = BEQ;
    settle(); chk("stall_first", 32'(bus.stall_FETCH), 32'd1); adv();
    settle(); chk("stall_second", 32'(bus.stall_FETCH), 32'd0); adv();

    bus.instr = NOP;
    adv();
    bus.instr = BEQ; rst = 1'b1;
    settle(); chk("stall_in_reset", 32'(bus.stall_FETCH), 32'd1); adv();
    rst = 1'b0;
    settle(); chk("stall_after_reset", 32'(bus.stall_FETCH), 32'd1); adv();

    for (int n = 0; n < 3000; n++) begin
      int k;
      bus.instr    = rand_instr();
      bus.ex_instr = rand_instr();
      k = $urandom_range(0, 3);
      bus.R_EX = (k == 0) ? 32'd0 : (k == 1) ? 32'd1 : $urandom;
      bus.wb_we   = ($urandom_range(0, 1) != 0);
      bus.wb_addr = ($urandom_range(0, 3) == 0) ? bus.instr[19:15] : 5'($urandom);
      k = $urandom_range(0, 7);
      bus.wb_data = (k == 0) ? 32'd0 : (k == 1) ? 32'hFFFFFFFF :
                    (k == 2) ? 32'h80000000 : (k == 3) ? 32'd1 : $urandom;
      rst = ($urandom_range(0, 199) == 0);
      adv();
    end

    check_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
